// File: rtl/mcpu_pkg.sv
// Shared definitions for the CPU memory-port sequencer: size codes, FSM states
// and the size-to-byte-count mapping.
package mcpu_pkg;

    localparam logic [1:0] SZ_1B = 2'b00;
    localparam logic [1:0] SZ_2B = 2'b01;
    localparam logic [1:0] SZ_4B = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    // Code 2'b11 is an alias of the 4-byte size.
    function automatic logic [2:0] size_to_bytes(input logic [1:0] sz);
        case (sz)
            SZ_1B:   return 3'd1;
            SZ_2B:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// CPU-side request/response bundle of the memory access sequencer.
interface mem_access_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sext;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, size, sext, addr, wdata,
        input  ready, done, rdata
    );

    modport slave (
        input  req, we, size, sext, addr, wdata,
        output ready, done, rdata
    );
endinterface

// File: rtl/mem_byte_lane.sv
// Byte insert into the load shadow register and sign/zero extension of the
// assembled value above the transfer length.
module mem_byte_lane #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] shadow,
    input  logic [1:0]        idx,
    input  logic [7:0]        byte_in,
    input  logic [2:0]        nbytes,
    input  logic              sext,
    output logic [DATA_W-1:0] shadow_ins,
    output logic [DATA_W-1:0] extended
);
    logic sign;

    always_comb begin
        shadow_ins = shadow;
        shadow_ins[{idx, 3'b000} +: 8] = byte_in;
    end

    always_comb begin
        case (nbytes)
            3'd1:    sign = shadow_ins[7];
            3'd2:    sign = shadow_ins[15];
            default: sign = shadow_ins[31];
        endcase
    end

    always_comb begin
        extended = '0;
        for (int k = 0; k < DATA_W / 8; k++) begin
            if (k < int'(nbytes)) extended[8*k +: 8] = shadow_ins[8*k +: 8];
            else                  extended[8*k +: 8] = {8{sext & sign}};
        end
    end
endmodule

// File: rtl/mem_access_seq.sv
// Bus-master side of the byte-wide RAM port: splits 1/2/4-byte CPU loads and
// stores into single-byte RAM cycles, little-endian.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready; a req at the edge latches operands, starts transfer
// ST_XFER | one RAM byte per cycle at base+cnt; last byte returns to IDLE
module mem_access_seq
    import mcpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_access_seq_if.slave   cpu,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_d,
    input  logic [7:0]        ram_q
);
    state_t            state, state_d;
    logic [1:0]        cnt, cnt_d, cnt_nx, last_idx;
    logic [2:0]        nbytes;
    logic              we_q, sext_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q, shadow, rdata_q, shadow_ins, load_ext;
    logic              done_q, done_d, ram_load_d;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [7:0]        ram_d_d;
    logic              accept, capture, last;

    assign nbytes   = size_to_bytes(size_q);
    assign last_idx = 2'(nbytes - 3'd1);
    assign last     = (cnt == last_idx);
    assign cnt_nx   = cnt + 2'd1;

    assign cpu.ready = (state == ST_IDLE);
    assign cpu.done  = done_q;
    assign cpu.rdata = rdata_q;

    // RAM address/data for the next cycle are computed here and registered,
    // so nothing reaches the RAM port combinationally from the CPU side.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        ram_load_d = 1'b0;
        ram_addr_d = ram_addr;
        ram_d_d    = ram_d;
        done_d     = 1'b0;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu.req) begin
                    accept     = 1'b1;
                    state_d    = ST_XFER;
                    cnt_d      = '0;
                    ram_addr_d = cpu.addr;
                    ram_d_d    = cpu.wdata[7:0];
                    ram_load_d = cpu.we;
                end
            end
            ST_XFER: begin
                capture = ~we_q;
                if (last) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d      = cnt_nx;
                    ram_addr_d = base_q + ADDR_W'(cnt_nx);
                    ram_d_d    = wdata_q[{cnt_nx, 3'b000} +: 8];
                    ram_load_d = we_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            we_q     <= 1'b0;
            sext_q   <= 1'b0;
            size_q   <= SZ_1B;
            base_q   <= '0;
            wdata_q  <= '0;
            shadow   <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            ram_load <= 1'b0;
            ram_addr <= '0;
            ram_d    <= '0;
        end else begin
            cnt      <= cnt_d;
            done_q   <= done_d;
            ram_load <= ram_load_d;
            ram_addr <= ram_addr_d;
            ram_d    <= ram_d_d;
            if (accept) begin
                we_q    <= cpu.we;
                sext_q  <= cpu.sext;
                size_q  <= cpu.size;
                base_q  <= cpu.addr;
                wdata_q <= cpu.wdata;
            end
            if (capture) shadow <= shadow_ins;
            if (capture && last) rdata_q <= load_ext;
        end
    end

    mem_byte_lane #(.DATA_W(DATA_W)) u_lane (
        .shadow     (shadow),
        .idx        (cnt),
        .byte_in    (ram_q),
        .nbytes     (nbytes),
        .sext       (sext_q),
        .shadow_ins (shadow_ins),
        .extended   (load_ext)
    );
endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: directed scenarios plus random traffic
// against a byte-array reference model of the RAM.
module tb_mem_access_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ram_load;
    logic [15:0] ram_addr;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;

    logic [7:0]  mem     [65536];
    logic [7:0]  ref_mem [65536];
    logic [31:0] last_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        int          acc;
        int          n;
    } exp_t;
    exp_t sbq[$];

    mem_access_seq_if #(.ADDR_W(16), .DATA_W(32)) cpu_if ();

    mem_access_seq #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu      (cpu_if),
        .ram_load (ram_load),
        .ram_addr (ram_addr),
        .ram_d    (ram_d),
        .ram_q    (ram_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: combinational read, synchronous write
    assign ram_q = mem[ram_addr];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        forever begin
            @(posedge clk);
            if (ram_load) mem[ram_addr] <= ram_d;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: stores patch the byte array, loads gather and extend bytes.
    task automatic model(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [15:0] a, input logic [31:0] wd, input int acc);
        exp_t e;
        int n;
        logic [15:0] ak;
        longint unsigned v;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (w) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 16'(k);
                ref_mem[ak] = wd[8*k +: 8];
            end
        end else begin
            v = 0;
            for (int k = 0; k < n; k++) begin
                ak = a + 16'(k);
                v = v + (longint'(ref_mem[ak]) << (8 * k));
            end
            if (sx && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
            last_rdata = v[31:0];
        end
        e.rdata = last_rdata;
        e.acc   = acc;
        e.n     = n;
        sbq.push_back(e);
    endtask

    task automatic issue(input bit w, input logic [1:0] sz, input bit sx,
                         input logic [15:0] a, input logic [31:0] wd,
                         input bit track, output int acc);
        int t;
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.we = w; cpu_if.size = sz;
        cpu_if.sext = sx; cpu_if.addr = a; cpu_if.wdata = wd;
        t = 0;
        while (!cpu_if.ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!cpu_if.ready) begin
            errors++;
            $display("FAIL accept_timeout ready=%0b required=1", cpu_if.ready);
            cpu_if.req = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        if (track) model(w, sz, sx, a, wd, acc);
        @(posedge clk);
        #1;
        cpu_if.req   = 1'b0;
        cpu_if.we    = 1'($urandom);
        cpu_if.size  = 2'($urandom);
        cpu_if.sext  = 1'($urandom);
        cpu_if.addr  = 16'($urandom);
        cpu_if.wdata = $urandom;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", sbq.size());
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n && cpu_if.done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL spurious_done at cycle %0d got=1 required=0", cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (cpu_if.rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL rdata got=%h required=%h", cpu_if.rdata, e.rdata);
                end
                checks++;
                if (cyc - e.acc != e.n) begin
                    errors++;
                    $display("FAIL latency got=%0d required=%0d", cyc - e.acc, e.n);
                end
            end
        end
    end

    initial begin
        int acc, acc2, bad;
        bit w;
        logic [15:0] a;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 7 + 3);
        cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.size = 2'b00;
        cpu_if.sext = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cpu_if.ready), 32'd1);
        chk("rst_done", 32'(cpu_if.done), 32'd0);
        chk("rst_rdata", cpu_if.rdata, 32'd0);
        chk("rst_ram_load", 32'(ram_load), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_d", 32'(ram_d), 32'd0);
        rst_n = 1'b1;

        // 1: 4-byte store
        issue(1'b1, 2'b10, 1'b0, 16'h0049, 32'h0000FFF8, 1'b1, acc);
        drain();
        chk("st4_b0", 32'(mem[16'h0049]), 32'hF8);
        chk("st4_b1", 32'(mem[16'h004A]), 32'hFF);
        chk("st4_b2", 32'(mem[16'h004B]), 32'h00);
        chk("st4_b3", 32'(mem[16'h004C]), 32'h00);

        // 2: 1-byte load, sign and zero extension
        issue(1'b1, 2'b00, 1'b0, 16'h0010, 32'h00000080, 1'b1, acc);
        issue(1'b0, 2'b00, 1'b1, 16'h0010, 32'h0, 1'b1, acc);
        drain();
        chk("ld1_sext", cpu_if.rdata, 32'hFFFFFF80);
        issue(1'b0, 2'b00, 1'b0, 16'h0010, 32'h0, 1'b1, acc);
        drain();
        chk("ld1_zext", cpu_if.rdata, 32'h00000080);

        // 3: address wrap
        issue(1'b1, 2'b01, 1'b0, 16'hFFFF, 32'h0000BEEF, 1'b1, acc);
        drain();
        chk("wrap_ffff", 32'(mem[16'hFFFF]), 32'hEF);
        chk("wrap_0000", 32'(mem[16'h0000]), 32'hBE);

        // 4: back-to-back store then load, accepted in the done cycle
        issue(1'b1, 2'b11, 1'b0, 16'h0009, 32'h11223344, 1'b1, acc);
        issue(1'b0, 2'b10, 1'b0, 16'h0009, 32'h0, 1'b1, acc2);
        chk("b2b_gap", 32'(acc2 - acc), 32'd5);
        drain();
        chk("b2b_rdata", cpu_if.rdata, 32'h11223344);

        // 6: req pulse during XFER is ignored
        issue(1'b1, 2'b01, 1'b0, 16'h0030, 32'h00001234, 1'b1, acc);
        @(negedge clk);
        cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.size = 2'b10;
        cpu_if.addr = 16'h0040; cpu_if.wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 cpu_if.req = 1'b0;
        drain();
        chk("busy_b0", 32'(mem[16'h0030]), 32'h34);
        chk("busy_b1", 32'(mem[16'h0031]), 32'h12);
        chk("busy_ign", 32'(mem[16'h0040]), 32'(ref_mem[16'h0040]));

        // 5: reset two cycles into a 4-byte store
        issue(1'b1, 2'b10, 1'b0, 16'h0020, 32'hAABBCCDD, 1'b0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort_ram_load", 32'(ram_load), 32'd0);
        chk("abort_ready", 32'(cpu_if.ready), 32'd1);
        chk("abort_done", 32'(cpu_if.done), 32'd0);
        chk("abort_rdata", cpu_if.rdata, 32'd0);
        chk("abort_ram_addr", 32'(ram_addr), 32'd0);
        chk("abort_ram_d", 32'(ram_d), 32'd0);
        ref_mem[16'h0020] = 8'hDD;
        ref_mem[16'h0021] = 8'hCC;
        last_rdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_m20", 32'(mem[16'h0020]), 32'hDD);
        chk("abort_m21", 32'(mem[16'h0021]), 32'hCC);
        chk("abort_m22", 32'(mem[16'h0022]), 32'(ref_mem[16'h0022]));
        chk("abort_m23", 32'(mem[16'h0023]), 32'(ref_mem[16'h0023]));

        // random traffic over a small window and the wrap boundary
        for (int i = 0; i < 250; i++) begin
            w = 1'($urandom);
            a = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                            : 16'($urandom_range(0, 47));
            issue(w, 2'($urandom), 1'($urandom), a, $urandom, 1'b1, acc);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        bad = 0;
        for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
